instruction_encode: RTL and testbench

//  Inverse of the RV32I decoder: turns an op index plus rd/rs1/rs2/imm fields into a 32-bit RV32I word.

---
 rtl/instruction_encode.sv | 251 +++++++++++++++++++++++++
 tb/tb_instruction_encode.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encode.sv
// rtl/instruction_encode.sv - two-stage RV32I instruction encoder with address assignment
//
// Purpose: turns an op index plus rd/rs1/rs2/imm fields into a 32-bit RV32I word.
//   S1 checks the fields for legality and selects the format/opcode/funct fields.
//   S2 assembles the word, gives it the next byte address, and presents it downstream.
//   A saturating counter tracks illegal words that leave S2.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready        request handshake
//   in_op[5:0]                 op index 0..39 (lui .. ebreak)
//   in_rd, in_rs1, in_rs2      register fields
//   in_imm[31:0]               signed byte-level immediate (U-type: full value)
//   out_valid / out_ready      word handshake
//   out_instr[31:0]            encoded word (zero when out_err)
//   out_addr[31:0]             byte address of this word
//   out_err                    request was illegal
//   err_count[ERRCNT_W-1:0]    saturating count of illegal words consumed

module instruction_encode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERRCNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          in_op,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [31:0]         in_imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [31:0]         out_addr,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [3:0] {
        FMT_U, FMT_J, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_R, FMT_FENCE, FMT_SYS
    } fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // ---------------- handshake ----------------
    logic s1_full_q, s1_full_d;
    logic s2_full_q, s2_full_d;
    logic s1_load, s2_load, s2_can_load;

    assign s2_can_load = !s2_full_q || out_ready;
    assign s2_load     = s1_full_q && s2_can_load;
    assign in_ready    = !s1_full_q || s2_can_load;
    assign s1_load     = in_valid && in_ready;

    always_comb begin
        s1_full_d = s1_full_q;
        s2_full_d = s2_full_q;
        if (s1_load)      s1_full_d = 1'b1;
        else if (s2_load) s1_full_d = 1'b0;
        if (s2_load)        s2_full_d = 1'b1;
        else if (out_ready) s2_full_d = 1'b0;
    end

    // ---------------- S1: format select and legality ----------------
    fmt_e       fmt_d;
    logic [6:0] opc_d;
    logic [2:0] f3_d;
    logic [6:0] f7_d;
    logic       brk_d;
    logic       bad_op;
    logic       err_d;
    logic       imm_i_ok, imm_b_ok, imm_j_ok, imm_u_ok, imm_sh_ok;

    // Range checks expressed as sign-extension tests on the 32-bit immediate.
    assign imm_i_ok  = (in_imm[31:11] == {21{in_imm[11]}});
    assign imm_b_ok  = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
    assign imm_j_ok  = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
    assign imm_u_ok  = (in_imm[11:0] == 12'h000);
    assign imm_sh_ok = (in_imm[31:5] == 27'd0);

    always_comb begin
        fmt_d  = FMT_SYS;
        opc_d  = OPC_SYSTEM;
        f3_d   = 3'b000;
        f7_d   = 7'b0000000;
        bad_op = 1'b0;
        brk_d  = (in_op == 6'd39);
        case (in_op)
            6'd0:  begin fmt_d = FMT_U;     opc_d = OPC_LUI;                      end
            6'd1:  begin fmt_d = FMT_U;     opc_d = OPC_AUIPC;                    end
            6'd2:  begin fmt_d = FMT_J;     opc_d = OPC_JAL;                      end
            6'd3:  begin fmt_d = FMT_I;     opc_d = OPC_JALR;                     end
            6'd4:  begin fmt_d = FMT_B;     opc_d = OPC_BRANCH; f3_d = 3'b000;    end
            6'd5:  begin fmt_d = FMT_B;     opc_d = OPC_BRANCH; f3_d = 3'b001;    end
            6'd6:  begin fmt_d = FMT_B;     opc_d = OPC_BRANCH; f3_d = 3'b100;    end
            6'd7:  begin fmt_d = FMT_B;     opc_d = OPC_BRANCH; f3_d = 3'b101;    end
            6'd8:  begin fmt_d = FMT_B;     opc_d = OPC_BRANCH; f3_d = 3'b110;    end
            6'd9:  begin fmt_d = FMT_B;     opc_d = OPC_BRANCH; f3_d = 3'b111;    end
            6'd10: begin fmt_d = FMT_I;     opc_d = OPC_LOAD;   f3_d = 3'b000;    end
            6'd11: begin fmt_d = FMT_I;     opc_d = OPC_LOAD;   f3_d = 3'b001;    end
            6'd12: begin fmt_d = FMT_I;     opc_d = OPC_LOAD;   f3_d = 3'b010;    end
            6'd13: begin fmt_d = FMT_I;     opc_d = OPC_LOAD;   f3_d = 3'b100;    end
            6'd14: begin fmt_d = FMT_I;     opc_d = OPC_LOAD;   f3_d = 3'b101;    end
            6'd15: begin fmt_d = FMT_S;     opc_d = OPC_STORE;  f3_d = 3'b000;    end
            6'd16: begin fmt_d = FMT_S;     opc_d = OPC_STORE;  f3_d = 3'b001;    end
            6'd17: begin fmt_d = FMT_S;     opc_d = OPC_STORE;  f3_d = 3'b010;    end
            6'd18: begin fmt_d = FMT_I;     opc_d = OPC_OPIMM;  f3_d = 3'b000;    end
            6'd19: begin fmt_d = FMT_I;     opc_d = OPC_OPIMM;  f3_d = 3'b010;    end
            6'd20: begin fmt_d = FMT_I;     opc_d = OPC_OPIMM;  f3_d = 3'b011;    end
            6'd21: begin fmt_d = FMT_I;     opc_d = OPC_OPIMM;  f3_d = 3'b100;    end
            6'd22: begin fmt_d = FMT_I;     opc_d = OPC_OPIMM;  f3_d = 3'b110;    end
            6'd23: begin fmt_d = FMT_I;     opc_d = OPC_OPIMM;  f3_d = 3'b111;    end
            6'd24: begin fmt_d = FMT_SH;    opc_d = OPC_OPIMM;  f3_d = 3'b001;    end
            6'd25: begin fmt_d = FMT_SH;    opc_d = OPC_OPIMM;  f3_d = 3'b101;    end
            6'd26: begin fmt_d = FMT_SH;    opc_d = OPC_OPIMM;  f3_d = 3'b101; f7_d = F7_ALT; end
            6'd27: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b000;    end
            6'd28: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b000; f7_d = F7_ALT; end
            6'd29: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b001;    end
            6'd30: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b010;    end
            6'd31: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b011;    end
            6'd32: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b100;    end
            6'd33: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b101;    end
            6'd34: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b101; f7_d = F7_ALT; end
            6'd35: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b110;    end
            6'd36: begin fmt_d = FMT_R;     opc_d = OPC_OP;     f3_d = 3'b111;    end
            6'd37: begin fmt_d = FMT_FENCE; opc_d = OPC_FENCE;                    end
            6'd38: begin fmt_d = FMT_SYS;   opc_d = OPC_SYSTEM;                   end
            6'd39: begin fmt_d = FMT_SYS;   opc_d = OPC_SYSTEM;                   end
            default: bad_op = 1'b1;
        endcase
    end

    always_comb begin
        err_d = bad_op;
        case (fmt_d)
            FMT_U:        err_d = bad_op || !imm_u_ok;
            FMT_J:        err_d = bad_op || !imm_j_ok;
            FMT_I, FMT_S: err_d = bad_op || !imm_i_ok;
            FMT_B:        err_d = bad_op || !imm_b_ok;
            FMT_SH:       err_d = bad_op || !imm_sh_ok;
            default:      err_d = bad_op;
        endcase
    end

    fmt_e        s1_fmt_q;
    logic [6:0]  s1_opc_q;
    logic [2:0]  s1_f3_q;
    logic [6:0]  s1_f7_q;
    logic        s1_brk_q;
    logic        s1_err_q;
    logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [31:0] s1_imm_q;

    // ---------------- S2: word assembly ----------------
    logic [31:0] instr_d;

    always_comb begin
        instr_d = 32'h0;
        case (s1_fmt_q)
            FMT_U:     instr_d = {s1_imm_q[31:12], s1_rd_q, s1_opc_q};
            FMT_J:     instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                  s1_rd_q, s1_opc_q};
            FMT_I:     instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
            FMT_SH:    instr_d = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
            FMT_S:     instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0],
                                  s1_opc_q};
            FMT_B:     instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                                  s1_imm_q[4:1], s1_imm_q[11], s1_opc_q};
            FMT_R:     instr_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
            FMT_FENCE: instr_d = {s1_imm_q[11:0], s1_rs1_q, 3'b000, s1_rd_q, s1_opc_q};
            // ebreak differs from ecall only in bit 20 (imm = 1).
            FMT_SYS:   instr_d = {11'b0, s1_brk_q, 13'b0, s1_opc_q};
            default:   instr_d = 32'h0;
        endcase
        if (s1_err_q) instr_d = 32'h0;
    end

    logic [31:0]         out_instr_q, out_addr_q, addr_q;
    logic                out_err_q;
    logic [ERRCNT_W-1:0] err_count_q;
    logic                err_inc;

    assign err_inc = s2_full_q && out_ready && out_err_q && (err_count_q != {ERRCNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full_q   <= 1'b0;
            s2_full_q   <= 1'b0;
            s1_fmt_q    <= FMT_SYS;
            s1_opc_q    <= 7'd0;
            s1_f3_q     <= 3'd0;
            s1_f7_q     <= 7'd0;
            s1_brk_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_rd_q     <= 5'd0;
            s1_rs1_q    <= 5'd0;
            s1_rs2_q    <= 5'd0;
            s1_imm_q    <= 32'd0;
            out_instr_q <= 32'd0;
            out_addr_q  <= 32'd0;
            out_err_q   <= 1'b0;
            addr_q      <= BASE_ADDR;
            err_count_q <= '0;
        end else begin
            s1_full_q <= s1_full_d;
            s2_full_q <= s2_full_d;
            if (s1_load) begin
                s1_fmt_q <= fmt_d;
                s1_opc_q <= opc_d;
                s1_f3_q  <= f3_d;
                s1_f7_q  <= f7_d;
                s1_brk_q <= brk_d;
                s1_err_q <= err_d;
                s1_rd_q  <= in_rd;
                s1_rs1_q <= in_rs1;
                s1_rs2_q <= in_rs2;
                s1_imm_q <= in_imm;
            end
            // Every word, legal or not, takes the next address as it enters S2.
            if (s2_load) begin
                out_instr_q <= instr_d;
                out_err_q   <= s1_err_q;
                out_addr_q  <= addr_q;
                addr_q      <= addr_q + 32'd4;
            end
            if (err_inc) begin
                err_count_q <= err_count_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = s2_full_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instruction_encode.sv
// tb/tb_instruction_encode.sv - scoreboard bench for instruction_encode

module tb_instruction_encode;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr, out_addr;
    logic [15:0] err_count;

    instruction_encode #(.BASE_ADDR(BASE), .ERRCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr;
    int          exp_errs;
    int          tests, fails;
    bit          rdy_rand;
    bit          held;
    logic [31:0] h_instr, h_addr;
    logic        h_err;
    int          w;

    localparam int F3 [40] = '{0,0,0,0, 0,1,4,5,6,7, 0,1,2,4,5, 0,1,2, 0,2,3,4,6,7,
                               1,5,5, 0,0,1,2,3,4,5,5,6,7, 0,0,0};
    localparam int BOUND [12] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096,
                                  1048574, -1048576, 1048576, 31, 32};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: returns {err, word}, computed from the field layout with plain arithmetic.
    function automatic logic [32:0] ref_model(input int op, input logic [31:0] rd,
                                              input logic [31:0] rs1, input logic [31:0] rs2,
                                              input logic [31:0] imm);
        int          s;
        bit          ok;
        logic [31:0] wd, f3, opc;
        s  = int'(imm);
        ok = 1'b1;
        wd = 32'h0;
        if (op > 39) return {1'b1, 32'h0};
        f3 = 32'(F3[op]);
        if (op <= 1) begin
            ok = (imm & 32'hFFF) == 32'h0;
            wd = (imm & 32'hFFFFF000) | (rd << 7) | (op == 0 ? 32'h37 : 32'h17);
        end else if (op == 2) begin
            ok = s >= -1048576 && s <= 1048574 && imm[0] == 1'b0;
            wd = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                 (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                 (rd << 7) | 32'h6F;
        end else if (op >= 4 && op <= 9) begin
            ok = s >= -4096 && s <= 4094 && imm[0] == 1'b0;
            wd = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                 (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                 (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
        end else if (op >= 15 && op <= 17) begin
            ok = s >= -2048 && s <= 2047;
            wd = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                 ((imm & 32'h1F) << 7) | 32'h23;
        end else if (op >= 24 && op <= 26) begin
            ok = imm < 32'd32;
            wd = (op == 26 ? 32'h40000000 : 32'h0) | ((imm & 32'h1F) << 20) | (rs1 << 15) |
                 (f3 << 12) | (rd << 7) | 32'h13;
        end else if (op >= 27 && op <= 36) begin
            wd = ((op == 28 || op == 34) ? 32'h40000000 : 32'h0) | (rs2 << 20) | (rs1 << 15) |
                 (f3 << 12) | (rd << 7) | 32'h33;
        end else if (op == 37) begin
            wd = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h0F;
        end else if (op == 38) begin
            wd = 32'h00000073;
        end else if (op == 39) begin
            wd = 32'h00100073;
        end else begin
            ok  = s >= -2048 && s <= 2047;
            opc = (op == 3) ? 32'h67 : ((op <= 14) ? 32'h03 : 32'h13);
            wd  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
        end
        return ok ? {1'b0, wd} : {1'b1, 32'h0};
    endfunction

    function automatic logic [31:0] rand_imm();
        int v;
        case ($urandom_range(0, 7))
            0: v = int'($urandom_range(0, 4095)) - 2048;
            1: v = int'($urandom);
            2: v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            3: v = int'($urandom_range(0, 40));
            4: v = int'($urandom & 32'hFFFFF000);
            5: v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            6: v = BOUND[$urandom_range(0, 11)];
            default: v = int'($urandom_range(0, 15)) - 8;
        endcase
        return 32'(v);
    endfunction

    task automatic push_const(input logic [31:0] instr, input logic err);
        sb.push_back('{instr: instr, addr: exp_addr, err: err});
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic push_model();
        logic [32:0] r;
        r = ref_model(int'(in_op), 32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm);
        push_const(r[31:0], r[32]);
    endtask

    // Called at posedge+1; leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input bit use_model,
                        input logic [31:0] c_instr, input bit c_err, output int waited);
        bit got;
        got    = 1'b0;
        waited = 0;
        in_op  = 6'(op);
        in_rd  = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_imm = imm;
        in_valid = 1'b1;
        while (!got && waited < 2000) begin
            @(negedge clk);
            waited++;
            if (in_ready) begin
                if (use_model) push_model();
                else push_const(c_instr, c_err);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready never seen for op %0d", op);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops one expectation per consumed word and checks held outputs while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (held && out_valid) begin
                check("stall_instr", out_instr, h_instr);
                check("stall_addr", out_addr, h_addr);
                check("stall_err", 32'(out_err), 32'(h_err));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h at %h, expected none", out_instr, out_addr);
                end else begin
                    e = sb.pop_front();
                    check("out_instr", out_instr, e.instr);
                    check("out_addr", out_addr, e.addr);
                    check("out_err", 32'(out_err), 32'(e.err));
                    check("err_count", 32'(err_count), 32'(exp_errs));
                    if (e.err) exp_errs++;
                end
            end
            held    = out_valid && !out_ready;
            h_instr = out_instr;
            h_addr  = out_addr;
            h_err   = out_err;
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int acc, total, op;
        tests = 0; fails = 0; rdy_rand = 1'b0; held = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 6'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        exp_addr = BASE; exp_errs = 0;

        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: accept at edge N, word visible after edge N+1.
        out_ready = 1'b1;
        in_op = 6'd18; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd5;
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_accept", 32'(in_ready), 32'd1);
        push_const(32'h00500093, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        send(0,  5'd5, 5'd9, 5'd3, 32'h12345000, 1'b0, 32'h123452B7, 1'b0, w);
        send(2,  5'd1, 5'd7, 5'd7, 32'd8,        1'b0, 32'h008000EF, 1'b0, w);
        send(39, 5'd7, 5'd4, 5'd2, 32'h00000FF0, 1'b0, 32'h00100073, 1'b0, w);
        send(38, 5'd3, 5'd3, 5'd3, 32'h00000123, 1'b0, 32'h00000073, 1'b0, w);
        send(4,  5'd9, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 32'hFE208EE3, 1'b0, w);
        send(28, 5'd3, 5'd1, 5'd2, 32'h00000777, 1'b0, 32'h402081B3, 1'b0, w);
        send(18, 5'd1, 5'd0, 5'd0, 32'd2048,     1'b0, 32'h0,        1'b1, w);
        send(45, 5'd1, 5'd2, 5'd3, 32'd0,        1'b0, 32'h0,        1'b1, w);
        in_valid = 1'b0;
        drain();
        check("errcnt_two", 32'(err_count), 32'd2);

        // Full throughput: every back-to-back request is taken on its first cycle.
        total = 0;
        for (int i = 0; i < 4; i++) begin
            send(27 + i, 5'($urandom), 5'($urandom), 5'($urandom), 32'd0, 1'b1, 32'h0, 1'b0, w);
            total += w;
        end
        in_valid = 1'b0;
        check("throughput_cycles", 32'(total), 32'd4);
        drain();

        // Legality boundaries.
        send(18, 5'd1, 5'd2, 5'd3, 32'(2047),     1'b1, 32'h0, 1'b0, w);
        send(18, 5'd1, 5'd2, 5'd3, 32'(-2048),    1'b1, 32'h0, 1'b0, w);
        send(18, 5'd1, 5'd2, 5'd3, 32'(-2049),    1'b1, 32'h0, 1'b0, w);
        send(4,  5'd1, 5'd2, 5'd3, 32'(4094),     1'b1, 32'h0, 1'b0, w);
        send(4,  5'd1, 5'd2, 5'd3, 32'(-4096),    1'b1, 32'h0, 1'b0, w);
        send(5,  5'd1, 5'd2, 5'd3, 32'(4096),     1'b1, 32'h0, 1'b0, w);
        send(6,  5'd1, 5'd2, 5'd3, 32'(3),        1'b1, 32'h0, 1'b0, w);
        send(2,  5'd1, 5'd2, 5'd3, 32'(1048574),  1'b1, 32'h0, 1'b0, w);
        send(2,  5'd1, 5'd2, 5'd3, 32'(-1048576), 1'b1, 32'h0, 1'b0, w);
        send(2,  5'd1, 5'd2, 5'd3, 32'(1048576),  1'b1, 32'h0, 1'b0, w);
        send(24, 5'd1, 5'd2, 5'd3, 32'(31),       1'b1, 32'h0, 1'b0, w);
        send(26, 5'd1, 5'd2, 5'd3, 32'(32),       1'b1, 32'h0, 1'b0, w);
        send(0,  5'd1, 5'd2, 5'd3, 32'h00000800,  1'b1, 32'h0, 1'b0, w);
        send(17, 5'd1, 5'd2, 5'd3, 32'(-2049),    1'b1, 32'h0, 1'b0, w);
        send(37, 5'd1, 5'd2, 5'd3, 32'h00000FFF,  1'b1, 32'h0, 1'b0, w);
        in_valid = 1'b0;
        drain();

        // Backpressure: with out_ready low only two requests fit.
        out_ready = 1'b0;
        in_op = 6'd18; in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd0; in_imm = 32'd1;
        in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready) begin
                push_model();
                acc++;
            end
            @(posedge clk); #1;
            in_rd  = in_rd + 5'd1;
            in_imm = in_imm + 32'd1;
        end
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_accepted", 32'(acc), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(18, in_rd, in_rs1, in_rs2, in_imm, 1'b1, 32'h0, 1'b0, w);
        in_valid = 1'b0;
        drain();

        // Randomized stream with random downstream stalls.
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 44));
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), rand_imm(), 1'b1, 32'h0, 1'b0, w);
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        drain();
        rdy_rand = 1'b0;
        out_ready = 1'b1;

        // Reset with both stages full.
        out_ready = 1'b0;
        send(21, 5'd4, 5'd5, 5'd6, 32'd7,  1'b1, 32'h0, 1'b0, w);
        send(18, 5'd1, 5'd0, 5'd0, 32'd99999, 1'b1, 32'h0, 1'b0, w);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_addr = BASE;
        exp_errs = 0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_instr", out_instr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_mid_errcnt", 32'(err_count), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send(18, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093, 1'b0, w);
        in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
